// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable wait states, byte/half/word access.
// Optional macro DMEM_ERR_CNT_EN adds a saturating err_count output for errored handshakes.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
`ifdef DMEM_ERR_CNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        write_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic             acc_write;
  logic [1:0]       acc_size;
  logic             acc_unsigned;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [IDX_W-1:0] acc_idx;
  logic             acc_err;
  logic             do_access;
  logic [31:0]      rd_word;
  logic [31:0]      ld_data;
  logic [3:0]       st_strobe;
  logic [31:0]      st_data;

  function automatic logic access_fault(input logic [1:0] size, input logic [31:0] addr);
    logic oob;
    oob = ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
    case (size)
      2'd0:    access_fault = oob;
      2'd1:    access_fault = oob | addr[0];
      2'd2:    access_fault = oob | (addr[1:0] != 2'b00);
      default: access_fault = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'd0:    load_extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    load_extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'd0:    store_strobe = 4'b0001 << lane;
      2'd1:    store_strobe = lane[1] ? 4'b1100 : 4'b0011;
      default: store_strobe = 4'b1111;
    endcase
  endfunction

  // Replicating the datum across lanes lets the strobe alone pick the target bytes.
  function automatic logic [31:0] store_align(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'd0:    store_align = {4{wdata[7:0]}};
      2'd1:    store_align = {2{wdata[15:0]}};
      default: store_align = wdata;
    endcase
  endfunction

  always_comb begin
    acc_write    = ZERO_WAIT ? req_write    : write_q;
    acc_size     = ZERO_WAIT ? req_size     : size_q;
    acc_unsigned = ZERO_WAIT ? req_unsigned : unsigned_q;
    acc_addr     = ZERO_WAIT ? req_addr     : addr_q;
    acc_wdata    = ZERO_WAIT ? req_wdata    : wdata_q;
    acc_idx      = acc_addr[IDX_W+1:2];
    acc_err      = access_fault(acc_size, acc_addr);
    rd_word      = mem[acc_idx];
    ld_data      = load_extract(rd_word, acc_size, acc_addr[1:0], acc_unsigned);
    st_strobe    = store_strobe(acc_size, acc_addr[1:0]);
    st_data      = store_align(acc_size, acc_wdata);
    if (ZERO_WAIT) do_access = reset && (state == ST_IDLE) && req_valid;
    else           do_access = reset && (state == ST_WAIT) && (cnt == 4'd0);
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);

  always_ff @(posedge clk) begin
    if (do_access && acc_write && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (st_strobe[b]) mem[acc_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      write_q    <= 1'b0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            write_q    <= req_write;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            if (ZERO_WAIT) begin
              resp_err   <= acc_err;
              resp_rdata <= (acc_err || acc_write) ? 32'd0 : ld_data;
              state      <= ST_RESP;
            end else begin
              cnt   <= CNT_INIT;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            resp_err   <= acc_err;
            resp_rdata <= (acc_err || acc_write) ? 32'd0 : ld_data;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DMEM_ERR_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= 16'd0;
    end else if ((state == ST_RESP) && resp_ready && resp_err && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expected responses, a monitor pops and compares.
module tb_dmem_responder;
  localparam int W = 2;
  localparam int D = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
`ifdef DMEM_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  dmem_responder #(.DEPTH_WORDS(D), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
`ifdef DMEM_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   first_seen = 0;
  int   last_start = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resp_valid && !prev_valid) first_seen = cyc;
    prev_valid = resp_valid;
    if (resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got rdata %h err %b expected no response", resp_rdata, resp_err);
      end else begin
        e = sb.pop_front();
        check({e.name, "_rdata"}, resp_rdata, e.rdata);
        check({e.name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
      end
    end
  end

  task automatic wait_accept(input string name);
    int n = 0;
    logic r;
    do begin
      @(negedge clk);
      r = req_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 50);
    if (!r) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: got req_ready 0 expected 1 within 50 cycles", name);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_resp_timeout: got no response expected one within 50 cycles", name);
      sb.delete();
    end
  endtask

  task automatic issue(input string name, input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic eerr, input logic [31:0] erdata);
    exp_t e;
    e.name = name;
    e.err = eerr;
    e.rdata = erdata;
    sb.push_back(e);
    last_start = cyc;
    req_write = wr;
    req_size = size;
    req_unsigned = uns;
    req_addr = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    wait_accept(name);
    req_valid = 1'b0;
    wait_drain(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_t e;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
`ifdef DMEM_ERR_CNT_EN
    check("rst_err_count", {16'd0, err_count}, 32'd0);
`endif
    @(posedge clk);
    #1;

    issue("sw_10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
    check("latency", 32'(first_seen - last_start), 32'(W + 1));
    issue("lw_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

    issue("sb_13", 1'b1, 2'd0, 1'b0, 32'h13, 32'hFFFFFF80, 1'b0, 32'd0);
    issue("lb_13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFFFF80);
    issue("lbu_13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0, 32'h00000080);
    issue("lw_10b", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'h80ADBEEF);
    issue("lh_12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFF80AD);
    issue("lhu_12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0, 32'h000080AD);

    issue("sh_10", 1'b1, 2'd1, 1'b0, 32'h10, 32'hCAFE1234, 1'b0, 32'd0);
    issue("lb_10", 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h00000034);
    issue("lb_11", 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0, 32'h00000012);
    issue("lw_10c", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'h80AD1234);

    issue("sw_ffc", 1'b1, 2'd2, 1'b0, 32'hFFC, 32'h0BADF00D, 1'b0, 32'd0);
    issue("lw_ffc", 1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0, 1'b0, 32'h0BADF00D);

    issue("sh_13_err", 1'b1, 2'd1, 1'b0, 32'h13, 32'h0000FFFF, 1'b1, 32'd0);
    issue("lw_11_err", 1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 1'b1, 32'd0);
    issue("lw_oob_err", 1'b0, 2'd2, 1'b0, 32'(D * 4), 32'h0, 1'b1, 32'd0);
    issue("sz3_err", 1'b1, 2'd3, 1'b0, 32'h10, 32'h0, 1'b1, 32'd0);
    issue("lw_10_after_err", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'h80AD1234);
`ifdef DMEM_ERR_CNT_EN
    check("err_count", {16'd0, err_count}, 32'd4);
`endif

    // Back-pressure: response must hold while a second request waits on req_valid.
    resp_ready = 1'b0;
    e.name = "hold_lw";
    e.err = 1'b0;
    e.rdata = 32'h80AD1234;
    sb.push_back(e);
    req_write = 1'b0;
    req_size = 2'd2;
    req_unsigned = 1'b0;
    req_addr = 32'h10;
    req_wdata = 32'h0;
    req_valid = 1'b1;
    wait_accept("hold_lw");
    req_write = 1'b1;
    req_wdata = 32'h00000000;
    n = 0;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rdata", resp_rdata, 32'h80AD1234);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    req_valid = 1'b0;
    wait_drain("hold_lw");
    check("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
    check("post_hs_resp_valid", {31'd0, resp_valid}, 32'd0);
    issue("lw_10_after_hold", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'h80AD1234);

    // Reset in WAIT must abort the store without touching memory.
    issue("sw_20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 1'b0, 32'd0);
    req_write = 1'b1;
    req_size = 2'd2;
    req_addr = 32'h20;
    req_wdata = 32'h55667788;
    req_valid = 1'b1;
    wait_accept("sw_20_abort");
    req_valid = 1'b0;
    check("wait_req_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort_resp_rdata", resp_rdata, 32'd0);
`ifdef DMEM_ERR_CNT_EN
    check("abort_err_count", {16'd0, err_count}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    issue("lw_20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11223344);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
